// File: rtl/axi_engine_arbiter_if.sv
// Requester, engine and status signals of the axi_engine_arbiter.
// The slave modport is the arbiter's own view. The master modport is the
// view of whatever drives the requests and models the engine.
interface axi_engine_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic                          resp_err;
    logic [DATA_WIDTH-1:0]         resp_rdata;

    // engine side
    logic                          start_wr;
    logic                          start_rd;
    logic [ADDR_WIDTH-1:0]         write_addr;
    logic [ADDR_WIDTH-1:0]         read_addr;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          end_wr;
    logic                          end_rd;
    logic [DATA_WIDTH-1:0]         read_data;

    // status
    logic                          busy;
    logic [GID_W-1:0]              grant_id;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, end_wr, end_rd, read_data,
        output req_ready, resp_valid, resp_err, resp_rdata,
               start_wr, start_rd, write_addr, read_addr, write_data, busy, grant_id
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, end_wr, end_rd, read_data,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               start_wr, start_rd, write_addr, read_addr, write_data, busy, grant_id
    );
endinterface

// File: rtl/axi_engine_arbiter.sv
// Round-robin arbiter that shares one axi_engine between NUM_REQ requesters.
// Each op is single-beat and is bounded by a timeout.
//
//   state | meaning
//   IDLE  | no op in flight; arbitrate among the valid requests
//   ISSUE | req_ready and start_* pulse; advance the round-robin pointer
//   WAIT  | wait for the matching end_*; the first two cycles are masked
//   RESP  | resp_valid pulse; arbitrate again so that starts are 5 cycles apart
module axi_engine_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int TIMEOUT    = 1024,
    parameter int TO_WIDTH   = 11
) (
    input  logic                 clk,
    input  logic                 resetn,
    axi_engine_arbiter_if.slave  bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [GID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]       grant_id_q, grant_id_d;
    logic                   is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;
    logic                   start_wr_q, start_wr_d;
    logic                   start_rd_q, start_rd_d;
    logic                   busy_q, busy_d;

    logic                   found;
    logic [GID_W-1:0]       pick;
    logic                   end_match;

    // Requester index at offset 'offset' from 'base', wrapping at NUM_REQ
    function automatic logic [GID_W-1:0] rr_idx(input logic [GID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return GID_W'(sum);
    endfunction

    // Pick the first valid requester at or after rr_ptr, scanning upward with wrap
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[rr_idx(rr_ptr_q, k)]) begin
                found = 1'b1;
                pick  = rr_idx(rr_ptr_q, k);
            end
        end
    end

    assign end_match = is_wr_q ? bus.end_wr : bus.end_rd;

    // Next-state and next-output logic of the op sequencer
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        is_wr_d      = is_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        to_cnt_d     = to_cnt_q;
        rdata_d      = rdata_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        start_wr_d   = 1'b0;
        start_rd_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (found) begin
                    grant_id_d        = pick;
                    is_wr_d           = bus.req_wr[pick];
                    addr_d            = bus.req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d           = bus.req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    req_ready_d[pick] = 1'b1;
                    start_wr_d        = bus.req_wr[pick];
                    start_rd_d        = !bus.req_wr[pick];
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rr_ptr_d = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + GID_W'(1);
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                // The engine's end_* may still be high from the previous op for two cycles.
                // A completion in the same cycle as the timeout wins over the timeout.
                if (to_cnt_q >= TO_WIDTH'(2) && end_match) begin
                    resp_valid_d[grant_id_q] = 1'b1;
                    if (!is_wr_q) rdata_d = bus.read_data;
                    state_d = ST_RESP;
                end else if (to_cnt_q >= TO_WIDTH'(TIMEOUT - 1)) begin
                    resp_valid_d[grant_id_q] = 1'b1;
                    resp_err_d               = 1'b1;
                    state_d                  = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; an async reset silently aborts any op in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            is_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            to_cnt_q     <= '0;
            rdata_q      <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            start_wr_q   <= 1'b0;
            start_rd_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            is_wr_q      <= is_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            to_cnt_q     <= to_cnt_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            start_wr_q   <= start_wr_d;
            start_rd_q   <= start_rd_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.start_wr   = start_wr_q;
    assign bus.start_rd   = start_rd_q;
    assign bus.write_addr = addr_q;
    assign bus.read_addr  = addr_q;
    assign bus.write_data = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_id_q;

endmodule

// File: tb/tb_axi_engine_arbiter.sv
// Directed bench for axi_engine_arbiter (4 requesters, TIMEOUT = 16).
module tb_axi_engine_arbiter;
    localparam int NR = 4;
    localparam int AW = 33;
    localparam int DW = 256;
    localparam logic [DW-1:0] RD_A5 = {32{8'hA5}};

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_engine_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_engine_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16), .TO_WIDTH(5)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.end_wr    = 1'b0;
        bus.end_rd    = 1'b0;
        bus.read_data = '0;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]           = 1'b1;
        bus.req_wr[i]              = wr;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Advance negedge by negedge until a start pulse is seen, at most 20 cycles
    task automatic wait_start(output bit seen);
        for (int i = 0; i < 20; i++) begin
            if (bus.start_wr || bus.start_rd) break;
            @(negedge clk);
        end
        seen = bus.start_wr || bus.start_rd;
    endtask

    // Engine model for a single op: end_* rises two cycles after the start,
    // then wait (bounded) for the response
    task automatic finish_op(input bit wr, input logic [DW-1:0] rd, output bit got);
        bus.end_wr = 1'b0;
        bus.end_rd = 1'b0;
        repeat (2) @(negedge clk);
        if (wr) bus.end_wr = 1'b1; else bus.end_rd = 1'b1;
        bus.read_data = rd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) break;
        end
        got = (bus.resp_valid != '0);
        bus.end_wr = 1'b0;
        bus.end_rd = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
        n_total++; if (bus.req_ready !== 4'b0) $display("FAIL reset_ready got %b exp 0000", bus.req_ready); else n_pass++;
        n_total++; if (bus.resp_valid !== 4'b0) $display("FAIL reset_resp got %b exp 0000", bus.resp_valid); else n_pass++;
        n_total++; if ({bus.start_wr, bus.start_rd} !== 2'b00) $display("FAIL reset_start got %b exp 00", {bus.start_wr, bus.start_rd}); else n_pass++;
        n_total++; if (bus.grant_id !== 2'd0) $display("FAIL reset_grant got %0d exp 0", bus.grant_id); else n_pass++;
        n_total++; if (bus.write_addr !== '0 || bus.read_addr !== '0) $display("FAIL reset_addr got %h/%h exp 0", bus.write_addr, bus.read_addr); else n_pass++;
        n_total++; if (bus.write_data !== '0 || bus.resp_rdata !== '0) $display("FAIL reset_data got %h/%h exp 0", bus.write_data, bus.resp_rdata); else n_pass++;
        n_total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.resp_err); else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        @(negedge clk);
        set_req(0, 1'b0, 33'h1_0000_0040, '0);
        @(negedge clk);
        n_total++; if ({bus.start_wr, bus.start_rd} !== 2'b01) $display("FAIL rd_start got %b exp 01", {bus.start_wr, bus.start_rd}); else n_pass++;
        n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL rd_ready got %b exp 0001", bus.req_ready); else n_pass++;
        n_total++; if (bus.read_addr !== 33'h1_0000_0040) $display("FAIL rd_addr got %h exp 100000040", bus.read_addr); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL rd_busy got %b exp 1", bus.busy); else n_pass++;
        bus.req_valid = '0;
        repeat (5) @(negedge clk);
        n_total++; if (bus.resp_valid !== 4'b0) $display("FAIL rd_early_resp got %b exp 0000", bus.resp_valid); else n_pass++;
        bus.end_rd    = 1'b1;
        bus.read_data = RD_A5;
        @(negedge clk);
        bus.end_rd    = 1'b0;
        bus.read_data = '0;
        n_total++; if (bus.resp_valid !== 4'b0001) $display("FAIL rd_resp got %b exp 0001", bus.resp_valid); else n_pass++;
        n_total++; if (bus.resp_rdata !== RD_A5) $display("FAIL rd_data got %h exp a5..a5", bus.resp_rdata); else n_pass++;
        n_total++; if (bus.resp_err !== 1'b0) $display("FAIL rd_err got %b exp 0", bus.resp_err); else n_pass++;
        @(negedge clk);
        n_total++; if ({bus.busy, bus.resp_valid} !== 5'b0) $display("FAIL rd_idle got %b exp 00000", {bus.busy, bus.resp_valid}); else n_pass++;
        n_total++; if (bus.read_addr !== 33'h1_0000_0040) $display("FAIL rd_addr_hold got %h exp 100000040", bus.read_addr); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
        int prev = 0;
        bit seen;
        do_reset();
        for (int i = 0; i < NR; i++)
            set_req(i, 1'b1, AW'(32'h100 * (i + 1)), DW'(32'hD0 + i));
        for (int g = 0; g < 6; g++) begin
            wait_start(seen);
            n_total++; if (!seen) $display("FAIL rr_start_timeout grant %0d got none exp start", g); else n_pass++;
            n_total++; if (bus.grant_id !== 2'(exp_ord[g])) $display("FAIL rr_grant #%0d got %0d exp %0d", g, bus.grant_id, exp_ord[g]); else n_pass++;
            n_total++; if (bus.req_ready !== (4'b0001 << exp_ord[g])) $display("FAIL rr_ready #%0d got %b exp %b", g, bus.req_ready, 4'b0001 << exp_ord[g]); else n_pass++;
            n_total++; if (bus.write_addr !== AW'(32'h100 * (exp_ord[g] + 1)) || bus.write_data !== DW'(32'hD0 + exp_ord[g]))
                $display("FAIL rr_bus #%0d got %h/%h exp grant %0d", g, bus.write_addr, bus.write_data[31:0], exp_ord[g]); else n_pass++;
            if (g > 0) begin
                n_total++; if (cyc - prev != 5) $display("FAIL rr_spacing #%0d got %0d exp 5", g, cyc - prev); else n_pass++;
            end
            prev = cyc;
            if (g == 5) bus.req_valid = '0;
            bus.end_wr = 1'b0;
            @(negedge clk);
            bus.end_wr = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid != '0) break;
            @(negedge clk);
        end
        n_total++; if (bus.resp_valid !== 4'b0010) $display("FAIL rr_last_resp got %b exp 0010", bus.resp_valid); else n_pass++;
        bus.end_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap_skip();
        bit seen, got;
        logic [DW-1:0] pat;
        pat = {8{32'h1234_5678}};
        set_req(2, 1'b0, 33'h0_0000_2000, '0);
        wait_start(seen);
        n_total++; if (!seen || bus.grant_id !== 2'd2) $display("FAIL wrap_grant2 got %0d seen %b exp 2", bus.grant_id, seen); else n_pass++;
        bus.req_valid = '0;
        finish_op(1'b0, pat, got);
        n_total++; if (!got || bus.resp_rdata !== pat) $display("FAIL wrap_rd2 got %h resp %b exp %h", bus.resp_rdata, got, pat); else n_pass++;
        set_req(1, 1'b1, 33'h0_0000_1000, DW'(32'hBEEF));
        wait_start(seen);
        n_total++; if (!seen || bus.grant_id !== 2'd1 || bus.req_ready !== 4'b0010) $display("FAIL wrap_skip_to1 got %0d/%b exp 1/0010", bus.grant_id, bus.req_ready); else n_pass++;
        bus.req_valid = '0;
        finish_op(1'b1, '0, got);
        n_total++; if (!got || bus.resp_valid !== 4'b0010) $display("FAIL wrap_resp1 got %b exp 0010", bus.resp_valid); else n_pass++;
        set_req(1, 1'b1, 33'h0_0000_1004, '0);
        set_req(2, 1'b1, 33'h0_0000_2004, '0);
        wait_start(seen);
        n_total++; if (!seen || bus.grant_id !== 2'd2) $display("FAIL wrap_ptr got %0d exp 2", bus.grant_id); else n_pass++;
        bus.req_valid = '0;
        finish_op(1'b1, '0, got);
        @(negedge clk);
    endtask

    task automatic test_stale_end();
        bit seen;
        bus.end_wr = 1'b1;
        set_req(3, 1'b1, 33'h0_0000_3000, DW'(32'h3333));
        wait_start(seen);
        n_total++; if (!seen || bus.start_wr !== 1'b1) $display("FAIL stale_start got %b exp 1", bus.start_wr); else n_pass++;
        bus.req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_total++; if (bus.resp_valid !== 4'b0) $display("FAIL stale_mask +%0d got %b exp 0000", k, bus.resp_valid); else n_pass++;
        end
        @(negedge clk);
        n_total++; if (bus.resp_valid !== 4'b1000 || bus.resp_err !== 1'b0) $display("FAIL stale_resp got %b err %b exp 1000 err 0", bus.resp_valid, bus.resp_err); else n_pass++;
        bus.end_wr = 1'b0;
        set_req(3, 1'b1, 33'h0_0000_3008, DW'(32'h4444));
        wait_start(seen);
        bus.req_valid = '0;
        bus.end_rd = 1'b1;
        repeat (6) @(negedge clk);
        n_total++; if ({bus.busy, bus.resp_valid} !== 5'b1_0000) $display("FAIL stray_end_rd got %b exp 10000", {bus.busy, bus.resp_valid}); else n_pass++;
        bus.end_rd = 1'b0;
        bus.end_wr = 1'b1;
        @(negedge clk);
        n_total++; if (bus.resp_valid !== 4'b1000) $display("FAIL stray_then_wr got %b exp 1000", bus.resp_valid); else n_pass++;
        bus.end_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit seen;
        set_req(0, 1'b0, 33'h1_0000_0080, '0);
        wait_start(seen);
        bus.req_valid = '0;
        repeat (16) @(negedge clk);
        n_total++; if (bus.resp_valid !== 4'b0) $display("FAIL to_early got %b exp 0000", bus.resp_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b1) $display("FAIL to_resp got %b err %b exp 0001 err 1", bus.resp_valid, bus.resp_err); else n_pass++;
        set_req(0, 1'b1, 33'h1_0000_00C0, DW'(32'h5555));
        wait_start(seen);
        bus.req_valid = '0;
        repeat (16) @(negedge clk);
        bus.end_wr = 1'b1;
        @(negedge clk);
        bus.end_wr = 1'b0;
        n_total++; if (bus.resp_valid !== 4'b0001 || bus.resp_err !== 1'b0) $display("FAIL to_tie got %b err %b exp 0001 err 0", bus.resp_valid, bus.resp_err); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit seen, got, saw_resp;
        set_req(2, 1'b1, 33'h0_0000_7000, DW'(32'h7777));
        wait_start(seen);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_total++; if ({bus.busy, bus.start_wr, bus.start_rd} !== 3'b0) $display("FAIL arst_ctrl got %b exp 000", {bus.busy, bus.start_wr, bus.start_rd}); else n_pass++;
        n_total++; if ({bus.req_ready, bus.resp_valid} !== 8'b0) $display("FAIL arst_hs got %b exp 0", {bus.req_ready, bus.resp_valid}); else n_pass++;
        n_total++; if (bus.grant_id !== 2'd0 || bus.write_addr !== '0 || bus.write_data !== '0) $display("FAIL arst_bus got %0d/%h/%h exp 0", bus.grant_id, bus.write_addr, bus.write_data); else n_pass++;
        @(negedge clk);
        bus.end_wr = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        bus.end_wr = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) saw_resp = 1'b1;
        end
        n_total++; if (saw_resp) $display("FAIL arst_no_resp got 1 exp 0"); else n_pass++;
        set_req(0, 1'b1, 33'h0_0000_0010, '0);
        set_req(3, 1'b1, 33'h0_0000_0030, '0);
        wait_start(seen);
        n_total++; if (!seen || bus.grant_id !== 2'd0) $display("FAIL arst_first_grant got %0d exp 0", bus.grant_id); else n_pass++;
        bus.req_valid = '0;
        finish_op(1'b1, '0, got);
        n_total++; if (!got) $display("FAIL arst_op_done got none exp resp"); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_wrap_skip();
        test_stale_end();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
